// File: rtl/alarm_key_entry_if.sv
// Keypad-to-clock bus: key strobes and one-second tick in, entry buffer and control flags out.
interface alarm_key_entry_if;
  logic       key_valid;
  logic [3:0] key;
  logic       one_second;
  logic [3:0] new_ms_hr;
  logic [3:0] new_ls_hr;
  logic [3:0] new_ms_min;
  logic [3:0] new_ls_min;
  logic       load_new_alarm;
  logic       load_new_time;
  logic       show_new_time;
  logic       show_a;
  logic       entry_error;

  modport master (
    output key_valid, key, one_second,
    input  new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
    input  load_new_alarm, load_new_time, show_new_time, show_a, entry_error
  );

  modport slave (
    input  key_valid, key, one_second,
    output new_ms_hr, new_ls_hr, new_ms_min, new_ls_min,
    output load_new_alarm, load_new_time, show_new_time, show_a, entry_error
  );
endinterface

// File: rtl/alarm_key_entry.sv
// Collects four HH:MM digits from the keypad, validates them and commits to the alarm or time register.
module alarm_key_entry #(
  parameter int unsigned TIMEOUT_SEC = 10
) (
  input  logic              clock,
  input  logic              reset,
  alarm_key_entry_if.slave  bus
);

  typedef enum logic [1:0] {
    SHOW_TIME  = 2'd0,
    KEY_ENTRY  = 2'd1,
    COMMIT     = 2'd2,
    SHOW_ALARM = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] buffer;
  logic [2:0]  count;
  logic [3:0]  timer;
  logic        target_alarm;
  logic        load_new_alarm;
  logic        load_new_time;
  logic        show_new_time;
  logic        show_a;
  logic        entry_error;

  logic key_ok;
  logic key_digit;
  logic timed_out;
  logic commit_ok;

  always_comb begin
    key_ok    = bus.key_valid && (bus.key <= 4'hB);
    key_digit = bus.key <= 4'h9;
    timed_out = timer == 4'(TIMEOUT_SEC);
    commit_ok = (count == 3'd4)
             && (buffer[15:12] <= 4'd2)
             && (buffer[11:8]  <= 4'd9)
             && !((buffer[15:12] == 4'd2) && (buffer[11:8] > 4'd3))
             && (buffer[7:4]   <= 4'd5)
             && (buffer[3:0]   <= 4'd9);
  end

  // Output registers decode the current state, so flags and strobes trail the state by one clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= SHOW_TIME;
      buffer         <= '0;
      count          <= '0;
      timer          <= '0;
      target_alarm   <= 1'b0;
      load_new_alarm <= 1'b0;
      load_new_time  <= 1'b0;
      show_new_time  <= 1'b0;
      show_a         <= 1'b0;
      entry_error    <= 1'b0;
    end else begin
      show_new_time  <= (state == KEY_ENTRY) || (state == COMMIT);
      show_a         <= state == SHOW_ALARM;
      load_new_alarm <= (state == COMMIT) && commit_ok && target_alarm;
      load_new_time  <= (state == COMMIT) && commit_ok && !target_alarm;
      entry_error    <= (state == COMMIT) && !commit_ok;

      case (state)
        SHOW_TIME: begin
          timer <= '0;
          if (key_ok && key_digit) begin
            buffer <= {12'h000, bus.key};
            count  <= 3'd1;
            state  <= KEY_ENTRY;
          end else if (key_ok && bus.key == 4'hA) begin
            state <= SHOW_ALARM;
          end
        end
        KEY_ENTRY: begin
          if (key_ok) begin
            timer <= '0;
            if (key_digit) begin
              buffer <= {buffer[11:0], bus.key};
              count  <= (count == 3'd4) ? 3'd4 : count + 3'd1;
            end else begin
              target_alarm <= bus.key == 4'hA;
              state        <= COMMIT;
            end
          end else if (timed_out) begin
            buffer <= '0;
            count  <= '0;
            timer  <= '0;
            state  <= SHOW_TIME;
          end else if (bus.one_second) begin
            timer <= timer + 4'd1;
          end
        end
        COMMIT: begin
          count <= '0;
          timer <= '0;
          state <= SHOW_TIME;
        end
        SHOW_ALARM: begin
          if (key_ok) begin
            timer <= '0;
            if (key_digit) begin
              buffer <= {12'h000, bus.key};
              count  <= 3'd1;
              state  <= KEY_ENTRY;
            end else begin
              state <= SHOW_TIME;
            end
          end else if (timed_out) begin
            timer <= '0;
            state <= SHOW_TIME;
          end else if (bus.one_second) begin
            timer <= timer + 4'd1;
          end
        end
        default: state <= SHOW_TIME;
      endcase
    end
  end

  assign bus.new_ms_hr      = buffer[15:12];
  assign bus.new_ls_hr      = buffer[11:8];
  assign bus.new_ms_min     = buffer[7:4];
  assign bus.new_ls_min     = buffer[3:0];
  assign bus.load_new_alarm = load_new_alarm;
  assign bus.load_new_time  = load_new_time;
  assign bus.show_new_time  = show_new_time;
  assign bus.show_a         = show_a;
  assign bus.entry_error    = entry_error;

endmodule
